mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, word-address width of the shared single-port RAM.
REQ-002 Parameter DATA_WIDTH, default 32, data word width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive lost-arbitration cycles before fetch is promoted (range 1..15).
REQ-004 Clk  input  1  sole clock, all state on rising edge.
REQ-005 ResetN  input  1  asynchronous, active-low reset.
REQ-006 FetchReq  input  1  instruction-fetch read request.
REQ-007 FetchAddr  input  ADDR_WIDTH  fetch word address.
REQ-008 FetchGnt  output  1  fetch request accepted this cycle.
REQ-009 FetchRdValid  output  1  fetch read data valid this cycle.
REQ-010 FetchRdData  output  DATA_WIDTH  fetch read data.
REQ-011 DataReq  input  1  load/store request.
REQ-012 DataWe  input  1  1 = store, 0 = load.
REQ-013 DataAddr  input  ADDR_WIDTH  load/store word address.
REQ-014 DataWrData  input  DATA_WIDTH  store data.
REQ-015 DataGnt  output  1  data request accepted this cycle.
REQ-016 DataRdValid  output  1  load data valid this cycle.
REQ-017 DataRdData  output  DATA_WIDTH  load data.
REQ-018 MemWrEn / MemAddr / MemWrData  output  1 / ADDR_WIDTH / DATA_WIDTH  RAM port drive.
REQ-019 MemRdData  input  DATA_WIDTH  RAM read data, one-cycle registered latency.

Function
REQ-020 At most one of FetchGnt/DataGnt SHALL be high per cycle; grants are combinational from requests and registered state.
REQ-021 Default priority: data wins when both request; a lone request is always granted the same cycle.
REQ-022 A requester SHALL hold Req and payload stable until it sees Gnt; Req with Gnt high completes the transfer in that cycle.
REQ-023 Mem outputs SHALL be driven from the winning port; MemWrEn = DataGnt & DataWe; with no grant MemWrEn = 0 and MemAddr/MemWrData hold their previous values.
REQ-024 Read owner register: after a granted fetch read, FetchRdValid = 1 exactly one cycle later; after a granted load, DataRdValid = 1 exactly one cycle later; stores produce no RdValid.
REQ-025 FetchRdData and DataRdData SHALL both equal MemRdData; consumers qualify with RdValid.
REQ-026 Back-to-back grants every cycle SHALL be supported (throughput 1 access/cycle, read latency 1).
REQ-027 Owner states OWN_NONE, OWN_FETCH, OWN_DATA: next state = granted port's read, else OWN_NONE; stores go to OWN_NONE.
REQ-028 Simultaneous request with a pending RdValid SHALL not stall; response and new grant coexist.

Reset
REQ-029 While ResetN = 0: FetchGnt, DataGnt, FetchRdValid, DataRdValid, MemWrEn = 0; MemAddr = 0; MemWrData = 0; owner = OWN_NONE; starvation counter = 0.
REQ-030 Reset asserted mid-read SHALL drop the pending RdValid; no response after release.
REQ-031 First grant possible in the first rising edge after ResetN deasserts.

Configuration
REQ-032 Macro MEM_ARB_STARVE_GUARD_EN defined: 4-bit counter increments each cycle FetchReq is high and not granted, clears on FetchGnt; when counter = STARVE_LIMIT, fetch wins over data for that cycle, then counter clears.
REQ-033 Macro undefined: pure fixed data priority, no counter logic present, STARVE_LIMIT ignored.

Structure
REQ-034 Shared package riscv_pkg SHALL hold the owner enum (OWN_NONE, OWN_FETCH, OWN_DATA) and default ADDR_WIDTH/DATA_WIDTH constants.
REQ-035 One sub-module starve_counter (saturating counter with clear/inc, limit-reached flag) instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-036 Fetch-only: FetchReq at addr 0x004, RAM word 0x00500093 -> FetchGnt same cycle, FetchRdValid next cycle with data 0x00500093.
REQ-037 Contention: FetchReq addr 0x008 and DataReq load addr 0x100 same cycle -> DataGnt=1, FetchGnt=0; next cycle DataRdValid=1, FetchGnt=1.
REQ-038 Store: DataReq, DataWe=1, addr 0x010, data 0xDEADBEEF -> MemWrEn=1 one cycle, no RdValid; subsequent load of 0x010 returns 0xDEADBEEF.
REQ-039 Starvation (macro on, STARVE_LIMIT=4): DataReq continuous, FetchReq held -> FetchGnt on 5th cycle, then data regains priority; macro off -> FetchGnt never while DataReq high.
REQ-040 Reset mid-read: grant load, assert ResetN=0 next cycle -> DataRdValid=0, all outputs at reset values, no response after release.
REQ-041 Streaming: fetch every cycle for 8 addresses 0..7 -> 8 consecutive FetchRdValid pulses, data in order.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and default widths for the memory-arbiter slice.
package riscv_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 9;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int STARVE_CNT_WIDTH   = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } ownerT;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating cycle counter that tracks how long instruction fetch has been
// losing arbitration; flags when the configured limit is reached.
module starve_counter
  import riscv_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic clear,
  input  logic inc,
  output logic limitHit
);

  localparam logic [STARVE_CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [STARVE_CNT_WIDTH-1:0] CNT_LIMIT = STARVE_CNT_WIDTH'(LIMIT);

  logic [STARVE_CNT_WIDTH-1:0] count;

  // Clear has priority so a promoted fetch always restarts the count from zero.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign limitHit = (count == CNT_LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port RAM between fetch and load/store.
// Optional fetch starvation guard enabled with MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  FetchReq,
  input  logic [ADDR_WIDTH-1:0] FetchAddr,
  output logic                  FetchGnt,
  output logic                  FetchRdValid,
  output logic [DATA_WIDTH-1:0] FetchRdData,
  input  logic                  DataReq,
  input  logic                  DataWe,
  input  logic [ADDR_WIDTH-1:0] DataAddr,
  input  logic [DATA_WIDTH-1:0] DataWrData,
  output logic                  DataGnt,
  output logic                  DataRdValid,
  output logic [DATA_WIDTH-1:0] DataRdData,
  output logic                  MemWrEn,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWrData,
  input  logic [DATA_WIDTH-1:0] MemRdData
);

  generate
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : gBadLimit
      $error("mem_arbiter: STARVE_LIMIT must be within 1..15");
    end
  endgenerate

  logic                  fetchWins;
  ownerT                 ownerState;
  ownerT                 ownerNext;
  logic [ADDR_WIDTH-1:0] heldAddr;
  logic [DATA_WIDTH-1:0] heldWrData;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic starveHit;

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) uStarveCounter (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .clear    (FetchGnt),
    .inc      (FetchReq & ~FetchGnt),
    .limitHit (starveHit)
  );

  assign fetchWins = FetchReq & (~DataReq | starveHit);
`else
  assign fetchWins = FetchReq & ~DataReq;
`endif

  // Grants are forced low while reset is asserted, even with requests pending.
  assign FetchGnt = ResetN & fetchWins;
  assign DataGnt  = ResetN & DataReq & ~fetchWins;
  assign MemWrEn  = DataGnt & DataWe;

  always_comb begin
    MemAddr   = heldAddr;
    MemWrData = heldWrData;
    if (DataGnt) begin
      MemAddr   = DataAddr;
      MemWrData = DataWrData;
    end else if (FetchGnt) begin
      MemAddr   = FetchAddr;
    end
  end

  // Remember the last RAM drive so an idle cycle leaves the bus unchanged.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      heldAddr   <= '0;
      heldWrData <= '0;
    end else begin
      heldAddr   <= MemAddr;
      heldWrData <= MemWrData;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ownerState <= OWN_NONE;
    end else begin
      ownerState <= ownerNext;
    end
  end

  // The owner records which port's read is returning on MemRdData next cycle.
  always_comb begin
    ownerNext = OWN_NONE;
    if (DataGnt && !DataWe) begin
      ownerNext = OWN_DATA;
    end else if (FetchGnt) begin
      ownerNext = OWN_FETCH;
    end
  end

  assign FetchRdValid = (ownerState == OWN_FETCH);
  assign DataRdValid  = (ownerState == OWN_DATA);
  assign FetchRdData  = MemRdData;
  assign DataRdData   = MemRdData;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected read
// responses, a negedge monitor pops them when RdValid appears.
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          Clk;
  logic          ResetN;
  logic          FetchReq;
  logic [AW-1:0] FetchAddr;
  logic          FetchGnt;
  logic          FetchRdValid;
  logic [DW-1:0] FetchRdData;
  logic          DataReq;
  logic          DataWe;
  logic [AW-1:0] DataAddr;
  logic [DW-1:0] DataWrData;
  logic          DataGnt;
  logic          DataRdValid;
  logic [DW-1:0] DataRdData;
  logic          MemWrEn;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWrData;
  logic [DW-1:0] MemRdData;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  typedef struct {
    logic          isFetch;
    logic [DW-1:0] data;
  } expT;

  expT expQ[$];
  int  checkCount = 0;
  int  passCount  = 0;

  mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(4)
  ) dut (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .FetchReq    (FetchReq),
    .FetchAddr   (FetchAddr),
    .FetchGnt    (FetchGnt),
    .FetchRdValid(FetchRdValid),
    .FetchRdData (FetchRdData),
    .DataReq     (DataReq),
    .DataWe      (DataWe),
    .DataAddr    (DataAddr),
    .DataWrData  (DataWrData),
    .DataGnt     (DataGnt),
    .DataRdValid (DataRdValid),
    .DataRdData  (DataRdData),
    .MemWrEn     (MemWrEn),
    .MemAddr     (MemAddr),
    .MemWrData   (MemWrData),
    .MemRdData   (MemRdData)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Single-port RAM with one-cycle registered read.
  always @(posedge Clk) begin
    if (MemWrEn) ram[MemAddr] <= MemWrData;
    MemRdData <= ram[MemAddr];
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic fReq, input logic [AW-1:0] fAddr,
                               input logic dReq, input logic dWe,
                               input logic [AW-1:0] dAddr, input logic [DW-1:0] dWr);
    FetchReq   = fReq;
    FetchAddr  = fAddr;
    DataReq    = dReq;
    DataWe     = dWe;
    DataAddr   = dAddr;
    DataWrData = dWr;
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic pushExp(input logic isFetch, input logic [DW-1:0] data);
    expT e;
    e.isFetch = isFetch;
    e.data    = data;
    expQ.push_back(e);
  endtask

  // Monitor: every RdValid must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (ResetN && (FetchRdValid || DataRdValid)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedRdValid", {30'd0, FetchRdValid, DataRdValid}, 32'd0);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("rdPortIsFetch", {31'd0, FetchRdValid}, {31'd0, e.isFetch});
        checkOutput("rdPortIsData", {31'd0, DataRdValid}, {31'd0, ~e.isFetch});
        checkOutput("rdData", e.isFetch ? FetchRdData : DataRdData, e.data);
      end
    end
  end

  initial begin
    logic [DW-1:0] expData;
    logic          expFetch;

    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
    for (int i = 0; i < 8; i++) ram[i] = 32'hA000_0000 + i;
    ram[4]     = 32'h0050_0093;
    ram[8]     = 32'h0000_0013;
    ram[9'h100] = 32'h1234_5678;

    // Reset with both requests asserted: everything must stay quiet.
    ResetN = 1'b0;
    applyStimulus(1'b1, 9'h0AA, 1'b1, 1'b1, 9'h055, 32'hFFFF_FFFF);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("rstFetchGnt", {31'd0, FetchGnt}, 32'd0);
    checkOutput("rstDataGnt", {31'd0, DataGnt}, 32'd0);
    checkOutput("rstFetchRdValid", {31'd0, FetchRdValid}, 32'd0);
    checkOutput("rstDataRdValid", {31'd0, DataRdValid}, 32'd0);
    checkOutput("rstMemWrEn", {31'd0, MemWrEn}, 32'd0);
    checkOutput("rstMemAddr", {23'd0, MemAddr}, 32'd0);
    checkOutput("rstMemWrData", MemWrData, 32'd0);

    // Fetch-only right after release.
    @(posedge Clk);
    #1;
    ResetN = 1'b1;
    applyStimulus(1'b1, 9'h004, 1'b0, 1'b0, 9'h000, 32'h0);
    @(negedge Clk);
    checkOutput("fetchOnlyGnt", {31'd0, FetchGnt}, 32'd1);
    checkOutput("fetchOnlyDataGnt", {31'd0, DataGnt}, 32'd0);
    checkOutput("fetchOnlyMemAddr", {23'd0, MemAddr}, 32'h4);
    if (FetchGnt) pushExp(1'b1, 32'h0050_0093);
    nextCycle();

    // Idle: no grant, bus holds.
    applyStimulus(1'b0, 9'h1FF, 1'b0, 1'b0, 9'h1FF, 32'h0);
    @(negedge Clk);
    checkOutput("idleFetchGnt", {31'd0, FetchGnt}, 32'd0);
    checkOutput("idleDataGnt", {31'd0, DataGnt}, 32'd0);
    checkOutput("idleMemAddrHold", {23'd0, MemAddr}, 32'h4);
    checkOutput("idleMemWrEn", {31'd0, MemWrEn}, 32'd0);
    nextCycle();

    // Contention: data wins, fetch follows next cycle.
    applyStimulus(1'b1, 9'h008, 1'b1, 1'b0, 9'h100, 32'h0);
    @(negedge Clk);
    checkOutput("contDataGnt", {31'd0, DataGnt}, 32'd1);
    checkOutput("contFetchGnt", {31'd0, FetchGnt}, 32'd0);
    checkOutput("contMemAddr", {23'd0, MemAddr}, 32'h100);
    if (DataGnt) pushExp(1'b0, 32'h1234_5678);
    nextCycle();
    applyStimulus(1'b1, 9'h008, 1'b0, 1'b0, 9'h000, 32'h0);
    @(negedge Clk);
    checkOutput("contFetchGnt2", {31'd0, FetchGnt}, 32'd1);
    checkOutput("contDataRdValid", {31'd0, DataRdValid}, 32'd1);
    if (FetchGnt) pushExp(1'b1, 32'h0000_0013);
    nextCycle();

    // Store then load back.
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF);
    @(negedge Clk);
    checkOutput("storeGnt", {31'd0, DataGnt}, 32'd1);
    checkOutput("storeMemWrEn", {31'd0, MemWrEn}, 32'd1);
    checkOutput("storeMemWrData", MemWrData, 32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0);
    @(negedge Clk);
    checkOutput("storeNoWrEn", {31'd0, MemWrEn}, 32'd0);
    checkOutput("storeNoRdValid", {30'd0, FetchRdValid, DataRdValid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0, 9'h010, 32'h0);
    @(negedge Clk);
    checkOutput("loadBackGnt", {31'd0, DataGnt}, 32'd1);
    if (DataGnt) pushExp(1'b0, 32'hDEAD_BEEF);
    nextCycle();

    // Starvation: continuous loads with fetch held for ten cycles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 9'h000, 1'b1, 1'b0, 9'h100, 32'h0);
      expFetch = GUARD && ((i == 4) || (i == 9));
      @(negedge Clk);
      checkOutput($sformatf("starveFetchGnt%0d", i), {31'd0, FetchGnt}, {31'd0, expFetch});
      checkOutput($sformatf("starveDataGnt%0d", i), {31'd0, DataGnt}, {31'd0, ~expFetch});
      if (FetchGnt) pushExp(1'b1, 32'hA000_0000);
      if (DataGnt) pushExp(1'b0, 32'h1234_5678);
      nextCycle();
    end
    applyStimulus(1'b1, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0);
    @(negedge Clk);
    checkOutput("starveReleaseFetchGnt", {31'd0, FetchGnt}, 32'd1);
    if (FetchGnt) pushExp(1'b1, 32'hA000_0000);
    nextCycle();

    // Reset mid-read: the pending load response is dropped.
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0, 9'h100, 32'h0);
    @(negedge Clk);
    checkOutput("midRstLoadGnt", {31'd0, DataGnt}, 32'd1);
    @(posedge Clk);
    #1;
    ResetN = 1'b0;
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0);
    @(negedge Clk);
    checkOutput("midRstDataRdValid", {31'd0, DataRdValid}, 32'd0);
    checkOutput("midRstMemAddr", {23'd0, MemAddr}, 32'd0);
    checkOutput("midRstMemWrData", MemWrData, 32'd0);
    checkOutput("midRstGnts", {30'd0, FetchGnt, DataGnt}, 32'd0);
    nextCycle();
    ResetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput($sformatf("postRstNoRd%0d", i), {30'd0, FetchRdValid, DataRdValid}, 32'd0);
      nextCycle();
    end

    // Streaming fetch of addresses 0..7, one per cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, AW'(i), 1'b0, 1'b0, 9'h000, 32'h0);
      expData = (i == 4) ? 32'h0050_0093 : (32'hA000_0000 + i);
      @(negedge Clk);
      checkOutput($sformatf("streamGnt%0d", i), {31'd0, FetchGnt}, 32'd1);
      if (FetchGnt) pushExp(1'b1, expData);
      nextCycle();
    end
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0);
    repeat (3) nextCycle();
    @(negedge Clk);
    checkOutput("scoreboardEmpty", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
